// File: rtl/universal_register_pkg.sv
// Shared types for the universal register: operation encoding and its width.
package universal_register_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_HOLD = 3'd0,
      OP_LOAD = 3'd1,
      OP_SHL  = 3'd2,
      OP_SHR  = 3'd3,
      OP_ROL  = 3'd4,
      OP_ROR  = 3'd5,
      OP_INC  = 3'd6,
      OP_DEC  = 3'd7
   } op_t;

endpackage

// File: rtl/universal_register_next.sv
// Combinational next-state for the universal register: new contents and
// carry/borrow/shift-out bit for the selected operation.
module universal_register_next
   import universal_register_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] q_i,
   input  op_t              op_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic             sin_i,
   output logic [WIDTH-1:0] next_q_o,
   output logic             next_co_o
);

   always_comb begin
      next_q_o  = q_i;
      next_co_o = 1'b0;
      case (op_i)
         OP_HOLD: begin
            next_q_o  = q_i;
            next_co_o = 1'b0;
         end
         OP_LOAD: begin
            next_q_o  = d_i;
            next_co_o = 1'b0;
         end
         OP_SHL: begin
            next_q_o  = {q_i[WIDTH-2:0], sin_i};
            next_co_o = q_i[WIDTH-1];
         end
         OP_SHR: begin
            next_q_o  = {sin_i, q_i[WIDTH-1:1]};
            next_co_o = q_i[0];
         end
         OP_ROL: begin
            next_q_o  = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            next_co_o = q_i[WIDTH-1];
         end
         OP_ROR: begin
            next_q_o  = {q_i[0], q_i[WIDTH-1:1]};
            next_co_o = q_i[0];
         end
         // Wrap detection is done on the old value, so no extra adder bit is needed.
         OP_INC: begin
            next_q_o  = q_i + {{(WIDTH-1){1'b0}}, 1'b1};
            next_co_o = &q_i;
         end
         OP_DEC: begin
            next_q_o  = q_i - {{(WIDTH-1){1'b0}}, 1'b1};
            next_co_o = ~|q_i;
         end
         default: begin
            next_q_o  = q_i;
            next_co_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/universal_register_async_reset.sv
// Universal register: hold/load/shift/rotate/count with async reset,
// synchronous clear, enable, registered carry-out and a zero flag.
module universal_register_async_reset
   import universal_register_pkg::*;
#(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  op_t              op,
   input  logic             sin,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             co,
   output logic             zero
);

   generate
      if (WIDTH < 2) begin : g_width_chk
         $error("universal_register_async_reset: WIDTH must be >= 2");
      end
   endgenerate

   logic [WIDTH-1:0] q_q;
   logic             co_q;
   logic [WIDTH-1:0] q_d;
   logic             co_d;

   universal_register_next #(
      .WIDTH(WIDTH)
   ) u_next (
      .q_i       (q_q),
      .op_i      (op),
      .d_i       (d),
      .sin_i     (sin),
      .next_q_o  (q_d),
      .next_co_o (co_d)
   );

   // Clear outranks enable; co only holds when the register is idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q  <= RESET_VAL;
         co_q <= 1'b0;
      end else if (clr) begin
         q_q  <= '0;
         co_q <= 1'b0;
      end else if (en) begin
         q_q  <= q_d;
         co_q <= co_d;
      end
   end

   assign q    = q_q;
   assign co   = co_q;
   assign zero = (q_q == '0);

endmodule

// File: tb/tb_universal_register_async_reset.sv
// Scoreboard bench: stimulus pushes expected q/co/zero, a monitor compares.
module tb_universal_register_async_reset;
   import universal_register_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 4-bit instance, RESET_VAL = 4'hA
   logic       reset4, en4, clr4, sin4;
   op_t        op4;
   logic [3:0] d4, q4;
   logic       co4, zero4;

   // 8-bit instance, RESET_VAL = 8'h80
   logic       reset8, en8, clr8, sin8;
   op_t        op8;
   logic [7:0] d8, q8;
   logic       co8, zero8;

   universal_register_async_reset #(.WIDTH(4), .RESET_VAL(4'hA)) dut4 (
      .clk(clk), .reset(reset4), .en(en4), .clr(clr4), .op(op4), .sin(sin4),
      .d(d4), .q(q4), .co(co4), .zero(zero4)
   );

   universal_register_async_reset #(.WIDTH(8), .RESET_VAL(8'h80)) dut8 (
      .clk(clk), .reset(reset8), .en(en8), .clr(clr8), .op(op8), .sin(sin8),
      .d(d8), .q(q8), .co(co8), .zero(zero8)
   );

   typedef struct {
      string      name;
      bit         wide;
      logic [7:0] q;
      logic       co;
      logic       zero;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   event kick;

   task automatic push(input string name, input bit wide, input logic [7:0] q, input logic co);
      exp_t e;
      e.name = name; e.wide = wide; e.q = q; e.co = co; e.zero = (q == 8'h00);
      sb.push_back(e);
   endtask

   // Monitor: compares at every falling edge, or on demand between edges.
   initial begin
      forever begin
         @(negedge clk or kick);
         while (sb.size() > 0) begin
            exp_t e;
            logic [7:0] aq;
            logic       aco, az;
            e = sb.pop_front();
            aq  = e.wide ? q8 : {4'h0, q4};
            aco = e.wide ? co8 : co4;
            az  = e.wide ? zero8 : zero4;
            tests++;
            if (aq !== e.q || aco !== e.co || az !== e.zero) begin
               fails++;
               $display("[TB] FAIL %s: got q=%h co=%b zero=%b, expected q=%h co=%b zero=%b",
                        e.name, aq, aco, az, e.q, e.co, e.zero);
            end else begin
               $display("[TB] ok   %s: q=%h co=%b zero=%b", e.name, aq, aco, az);
            end
         end
      end
   end

   task automatic step4(input string name, input logic en, input logic clr, input op_t op,
                        input logic sin, input logic [3:0] d,
                        input logic [3:0] eq, input logic eco);
      en4 = en; clr4 = clr; op4 = op; sin4 = sin; d4 = d;
      @(posedge clk);
      push(name, 1'b0, {4'h0, eq}, eco);
      @(negedge clk);
   endtask

   task automatic step8(input string name, input op_t op, input logic [7:0] eq, input logic eco);
      en8 = 1'b1; clr8 = 1'b0; op8 = op; sin8 = 1'b0; d8 = 8'h00;
      @(posedge clk);
      push(name, 1'b1, eq, eco);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] e8, p8;
      reset4 = 1'b1; en4 = 1'b0; clr4 = 1'b0; op4 = OP_HOLD; sin4 = 1'b0; d4 = 4'h0;
      reset8 = 1'b1; en8 = 1'b0; clr8 = 1'b0; op8 = OP_HOLD; sin8 = 1'b0; d8 = 8'h00;
      @(negedge clk);
      push("rst4_init", 1'b0, 8'h0A, 1'b0);
      push("rst8_init", 1'b1, 8'h80, 1'b0);
      -> kick;
      reset4 = 1'b0;

      step4("load5", 1'b1, 1'b0, OP_LOAD, 1'b0, 4'h5, 4'h5, 1'b0);
      // Asynchronous reset between edges
      #2 reset4 = 1'b1;
      #1 push("rst4_async", 1'b0, 8'h0A, 1'b0);
      -> kick;
      step4("load_in_reset", 1'b1, 1'b0, OP_LOAD, 1'b0, 4'h3, 4'hA, 1'b0);
      reset4 = 1'b0;
      step4("inc_from_rv",  1'b1, 1'b0, OP_INC,  1'b0, 4'h0, 4'hB, 1'b0);

      step4("loadF",        1'b1, 1'b0, OP_LOAD, 1'b0, 4'hF, 4'hF, 1'b0);
      step4("inc_wrap",     1'b1, 1'b0, OP_INC,  1'b0, 4'h0, 4'h0, 1'b1);
      step4("inc_again",    1'b1, 1'b0, OP_INC,  1'b0, 4'h0, 4'h1, 1'b0);
      step4("dec_to0",      1'b1, 1'b0, OP_DEC,  1'b0, 4'h0, 4'h0, 1'b0);
      step4("dec_wrap",     1'b1, 1'b0, OP_DEC,  1'b0, 4'h0, 4'hF, 1'b1);
      for (int i = 0; i < 3; i++)
         step4($sformatf("en0_hold%0d", i), 1'b0, 1'b0, OP_DEC, 1'b0, 4'h0, 4'hF, 1'b1);
      step4("hold_op",      1'b1, 1'b0, OP_HOLD, 1'b0, 4'h3, 4'hF, 1'b0);

      step4("load9",        1'b1, 1'b0, OP_LOAD, 1'b0, 4'h9, 4'h9, 1'b0);
      step4("shl_sin0",     1'b1, 1'b0, OP_SHL,  1'b0, 4'h0, 4'h2, 1'b1);
      step4("shr_sin1",     1'b1, 1'b0, OP_SHR,  1'b1, 4'h0, 4'h9, 1'b0);
      step4("ror",          1'b1, 1'b0, OP_ROR,  1'b0, 4'h0, 4'hC, 1'b1);
      step4("rol",          1'b1, 1'b0, OP_ROL,  1'b0, 4'h0, 4'h9, 1'b1);

      step4("clr_en0",      1'b0, 1'b1, OP_INC,  1'b0, 4'h0, 4'h0, 1'b0);
      step4("load7",        1'b1, 1'b0, OP_LOAD, 1'b0, 4'h7, 4'h7, 1'b0);
      step4("clr_over_load",1'b1, 1'b1, OP_LOAD, 1'b0, 4'h5, 4'h0, 1'b0);
      en4 = 1'b0; clr4 = 1'b0;

      // 8-bit instance: release reset, then a full wrap of increments
      reset8 = 1'b0;
      e8 = 8'h80;
      for (int i = 0; i < 256; i++) begin
         p8 = e8;
         e8 = p8 + 8'h01;
         step8($sformatf("inc8_%0d", i), OP_INC, e8, (p8 == 8'hFF));
      end
      en8 = 1'b0;

      #1;
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("[TB] FAIL sb_drain: %0d entries left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
